// File: rtl/ex_muldiv.sv
// Iterative multiply / divide / multiply-accumulate unit for the Execute stage.
// Owns the HI/LO pair; retires one bit of the operation per clock, so a normal
// operation takes WIDTH+1 cycles from the accepting edge to Done.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mtdata,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opnd;       // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0] p;          // {acc, multiplier} or {remainder, quotient}
    logic               neg_res;    // product / quotient sign flip
    logic               neg_rem;    // remainder follows dividend sign
    logic               dz_q;

    logic               accept, is_sgn, is_div, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod, res;

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start && !flush;
    assign is_sgn = ~op[0];
    assign is_div = (op[2:1] == 2'b01);
    assign b_zero = (b == '0);
    assign a_mag  = (is_sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag  = (is_sgn && b[WIDTH-1]) ? -b : b;

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? opnd : '0)};
        mul_next  = {mul_sum, p[WIDTH-1:1]};
        div_trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, opnd};
        div_next  = div_trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end

    // Final HI/LO value: sign fix-up, then accumulate against HI/LO as they are now.
    always_comb begin
        prod = neg_res ? -p : p;
        res  = prod;
        if (dz_q) begin
            res = p;                // preloaded with {A, all ones}
        end else begin
            case (op_q[2:1])
                2'b00: res = prod;
                2'b01: res = {(neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH]),
                              (neg_res ? -p[WIDTH-1:0] : p[WIDTH-1:0])};
                2'b10: res = {hi, lo} + prod;
                2'b11: res = {hi, lo} - prod;
                default: res = prod;
            endcase
        end
    end

    // Next-state logic. Divide-by-zero idles one cycle in CALC (cnt = 0, no
    // iteration) so its Done lands two edges after the accepting edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (flush) state_nxt = IDLE;
                  else if (cnt == '0) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand latch, iteration datapath and HI/LO write-back.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            opnd    <= '0;
            p       <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_q    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= mtdata;
                    if (mtlo) lo <= mtdata;
                    if (accept) begin
                        op_q    <= op;
                        divzero <= 1'b0;
                        neg_res <= is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= is_sgn && a[WIDTH-1];
                        dz_q    <= is_div && b_zero;
                        if (is_div && b_zero) begin
                            cnt  <= '0;
                            opnd <= '0;
                            p    <= {a, {WIDTH{1'b1}}};
                        end else if (is_div) begin
                            cnt  <= CW'(WIDTH - 1);
                            opnd <= b_mag;
                            p    <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            cnt  <= CW'(WIDTH - 1);
                            opnd <= a_mag;
                            p    <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        cnt <= cnt - 1'b1;
                        if (!dz_q) p <= (op_q[2:1] == 2'b01) ? div_next : mul_next;
                    end
                end
                FIN: begin
                    if (!flush) begin
                        hi      <= res[2*WIDTH-1:WIDTH];
                        lo      <= res[WIDTH-1:0];
                        done    <= 1'b1;
                        divzero <= dz_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (WIDTH = 32): expected values are hand-computed.
module tb_ex_muldiv;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        flush = 1'b0, mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] mtdata = '0;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                           MADD = 3'b100, MADDU = 3'b101, MSUB = 3'b110, MSUBU = 3'b111;

    ex_muldiv #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .mtdata(mtdata),
        .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    // Issue one operation from IDLE; n = edges after the accepting edge until Done.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic mt(input logic [31:0] h, input logic [31:0] l);
        mthi = 1'b1; mtdata = h;
        @(posedge clock); #1;
        mthi = 1'b0; mtlo = 1'b1; mtdata = l;
        @(posedge clock); #1;
        mtlo = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL reset_done got %0b want 0", done); end
        vectors++; if (divzero !== 1'b0) begin miscompares++; $display("FAIL reset_divzero got %0b want 0", divzero); end
        vectors++; if (hi !== 32'h0)     begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'h0)     begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_mult;
        int n;
        run_op(MULT, 32'hFFFF_FFFE, 32'd3, n);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL mult_latency got %0d want 33", n); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        @(posedge clock); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_single_pulse got %0b want 0", done); end
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        vectors++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
            begin miscompares++; $display("FAIL multu_max got %h want fffffffe00000001", {hi, lo}); end
    endtask

    task automatic test_accumulate;
        int n;
        // 0xFFFFFFFF*2 = 0x1_FFFFFFFE, plus 10 = 0x2_00000008
        mt(32'h0, 32'd10);
        run_op(MADDU, 32'hFFFF_FFFF, 32'd2, n);
        vectors++; if (hi !== 32'h2) begin miscompares++; $display("FAIL maddu_hi got %h want 00000002", hi); end
        vectors++; if (lo !== 32'h8) begin miscompares++; $display("FAIL maddu_lo got %h want 00000008", lo); end
        // -1 - (3 * -4) = 11
        mt(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MSUB, 32'd3, 32'hFFFF_FFFC, n);
        vectors++; if ({hi, lo} !== 64'd11) begin miscompares++; $display("FAIL msub_signed got %h want 000000000000000b", {hi, lo}); end
        // MTLO in the Start cycle: {0,5} + 2*3 = 11
        mtlo = 1'b1; mtdata = 32'd5;
        run_op(MADD, 32'd2, 32'd3, n);
        mtlo = 1'b0;
        vectors++; if ({hi, lo} !== 64'd11) begin miscompares++; $display("FAIL madd_mt_same_cycle got %h want 000000000000000b", {hi, lo}); end
    endtask

    task automatic test_div;
        int n;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, n);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL div_latency got %0d want 33", n); end
        vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_quot got %h want fffffffd", lo); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg_rem got %h want ffffffff", hi); end
        vectors++; if (divzero !== 1'b0) begin miscompares++; $display("FAIL div_divzero got %0b want 0", divzero); end
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, n);
        vectors++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin miscompares++; $display("FAIL div_pos_by_neg got %h want 00000001fffffffd", {hi, lo}); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        vectors++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin miscompares++; $display("FAIL div_overflow got %h want 0000000080000000", {hi, lo}); end
        run_op(DIVU, 32'd100, 32'd7, n);
        vectors++; if ({hi, lo} !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL divu got %h want 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_divzero;
        int n;
        run_op(DIVU, 32'd5, 32'd0, n);
        vectors++; if (n !== 2) begin miscompares++; $display("FAIL dz_latency got %0d want 2", n); end
        vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL dz_lo got %h want ffffffff", lo); end
        vectors++; if (hi !== 32'd5) begin miscompares++; $display("FAIL dz_hi got %h want 00000005", hi); end
        vectors++; if (divzero !== 1'b1) begin miscompares++; $display("FAIL dz_flag got %0b want 1", divzero); end
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (divzero !== 1'b1) begin miscompares++; $display("FAIL dz_hold got %0b want 1", divzero); end
        run_op(DIV, 32'd9, 32'd3, n);
        vectors++; if (divzero !== 1'b0) begin miscompares++; $display("FAIL dz_clear got %0b want 0", divzero); end
        vectors++; if ({hi, lo} !== {32'd0, 32'd3}) begin miscompares++; $display("FAIL div_after_dz got %h want 0000000000000003", {hi, lo}); end
    endtask

    task automatic test_flush;
        int seen;
        mt(32'h11, 32'h22);
        op = MULTU; a = 32'd5; b = 32'd6; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        // Flush at cycle 10, with a Start and an MTHI that must both be ignored
        flush = 1'b1; start = 1'b1; mthi = 1'b1; mtdata = 32'hDEAD;
        @(posedge clock); #1;
        flush = 1'b0; start = 1'b0; mthi = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %0b want 0", busy); end
        vectors++; if ({hi, lo} !== {32'h11, 32'h22}) begin miscompares++; $display("FAIL flush_hilo got %h want 0000001100000022", {hi, lo}); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done || busy) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_no_done got %0d active cycles want 0", seen); end
        start = 1'b1; flush = 1'b1; op = DIVU; a = 32'd1; b = 32'd1;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_start got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int n;
        op = DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        vectors++; if ({busy, done, divzero} !== 3'b000) begin miscompares++; $display("FAIL midreset_flags got %b want 000", {busy, done, divzero}); end
        vectors++; if ({hi, lo} !== 64'd0) begin miscompares++; $display("FAIL midreset_hilo got %h want 0", {hi, lo}); end
        run_op(DIVU, 32'd100, 32'd7, n);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL post_reset_latency got %0d want 33", n); end
        vectors++; if ({hi, lo} !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL post_reset_divu got %h want 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_back_to_back;
        int n;
        run_op(MULT, 32'd7, 32'hFFFF_FFFD, n);
        vectors++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin miscompares++; $display("FAIL b2b_first got %h want ffffffffffffffeb", {hi, lo}); end
        // Started in the Done cycle
        run_op(MULTU, 32'h0001_0000, 32'h0001_0000, n);
        vectors++; if (n !== 33) begin miscompares++; $display("FAIL b2b_latency got %0d want 33", n); end
        vectors++; if ({hi, lo} !== 64'h0000_0001_0000_0000) begin miscompares++; $display("FAIL b2b_second got %h want 0000000100000000", {hi, lo}); end
        // {1,0} - 1*1 borrows across LO
        run_op(MSUBU, 32'd1, 32'd1, n);
        vectors++; if ({hi, lo} !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL msubu_borrow got %h want 00000000ffffffff", {hi, lo}); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_accumulate;
        test_div;
        test_divzero;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
